// File: rtl/jlsemi_util_smic_efuse_pkg.sv
// ---------------------------------------------------------------------------
// jlsemi_util_smic_efuse_pkg
// Shared definitions for the SMIC eFuse responder model:
//   efuse_state_e   - responder FSM states
//   ERR_*           - bit positions inside the sticky err vector
//   EFUSE_OCT_BITS  - bits per fuse octet
//   EFUSE_BIT_IDX_W - width of the bit-in-octet index carried on A
// ---------------------------------------------------------------------------
package jlsemi_util_smic_efuse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_PULSE  = 2'd1,
        ST_PG_PULSE  = 2'd2,
        ST_BAD_PULSE = 2'd3
    } efuse_state_e;

    localparam int ERR_RD_PG = 0;   // AEN rise with RDEN/PGMEN both set or both clear
    localparam int ERR_A_CHG = 1;   // A moved while AEN high
    localparam int ERR_SHORT = 2;   // pulse shorter than the minimum width
    localparam int ERR_AVDD  = 3;   // AVDD_EN low during a program pulse
    localparam int ERR_W     = 4;

    localparam int EFUSE_OCT_BITS  = 8;
    localparam int EFUSE_BIT_IDX_W = 3;

endpackage

// File: rtl/jlsemi_util_smic_efuse_emu_array.sv
// ---------------------------------------------------------------------------
// jlsemi_util_smic_efuse_emu_array
// Flop array standing in for the fuse cells. Bits only ever go 0->1.
// Ports:
//   clk, rst              clock and synchronous active-high reset (virgin fuse)
//   wr_en/wr_oct/wr_bit   blow one bit of one octet
//   rd_oct/rd_data        combinational read, registered into D by the top
//   peek_oct/peek_data    backdoor read, 1-cycle registered latency
// ---------------------------------------------------------------------------
module jlsemi_util_smic_efuse_emu_array
    import jlsemi_util_smic_efuse_pkg::*;
#(
    parameter int OCT_AW = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [OCT_AW-1:0]          wr_oct,
    input  logic [EFUSE_BIT_IDX_W-1:0] wr_bit,
    input  logic [OCT_AW-1:0]          rd_oct,
    output logic [EFUSE_OCT_BITS-1:0]  rd_data,
    input  logic [OCT_AW-1:0]          peek_oct,
    output logic [EFUSE_OCT_BITS-1:0]  peek_data
);

    localparam int N_OCT = 1 << OCT_AW;

    logic [EFUSE_OCT_BITS-1:0] oct_arr [N_OCT];
    logic [EFUSE_OCT_BITS-1:0] bit_mask;
    logic [EFUSE_OCT_BITS-1:0] peek_data_reg;

    assign bit_mask = EFUSE_OCT_BITS'(1) << wr_bit;

    genvar gi;
    generate
        for (gi = 0; gi < N_OCT; gi++) begin : g_oct
            logic [EFUSE_OCT_BITS-1:0] oct_reg;

            // OR-in the mask: re-blowing a set bit leaves the octet unchanged
            always_ff @(posedge clk) begin
                if (rst) begin
                    oct_reg <= '0;
                end else if (wr_en && (wr_oct == OCT_AW'(gi))) begin
                    oct_reg <= oct_reg | bit_mask;
                end
            end

            assign oct_arr[gi] = oct_reg;
        end
    endgenerate

    assign rd_data = oct_arr[rd_oct];

    always_ff @(posedge clk) begin
        if (rst) begin
            peek_data_reg <= '0;
        end else begin
            peek_data_reg <= oct_arr[peek_oct];
        end
    end

    assign peek_data = peek_data_reg;

endmodule

// File: rtl/jlsemi_util_smic_efuse_emu.sv
// ---------------------------------------------------------------------------
// jlsemi_util_smic_efuse_emu
// Synchronous responder model of the SMIC eFuse macro. Samples the macro
// strobes on clk, blows bits on valid program pulses, returns octets on D
// for valid read pulses and raises sticky protocol flags.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   PGMEN, RDEN, AEN, A,
//   AVDD_EN                    macro-side strobes from the adapter
//   D                          read data octet
//   peek_addr/peek_data        backdoor octet read (registered)
//   pgm_cnt                    saturating count of accepted program pulses
//   err, err_clr               sticky violation flags and their clear
// Configuration macro: JLSEMI_SMIC_EFUSE_EMU_CHK_EN enables the width/AVDD
// checks and err flags; without it every pulse is accepted and err reads 0.
// ---------------------------------------------------------------------------
module jlsemi_util_smic_efuse_emu
    import jlsemi_util_smic_efuse_pkg::*;
#(
    parameter int EFUSE_DEPTH = 10,
    parameter int RD_MIN_CYC  = 4,
    parameter int PGM_MIN_CYC = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            PGMEN,
    input  logic                            RDEN,
    input  logic                            AEN,
    input  logic [EFUSE_DEPTH-1:0]          A,
    input  logic                            AVDD_EN,
    output logic [EFUSE_OCT_BITS-1:0]       D,
    input  logic [EFUSE_DEPTH-4:0]          peek_addr,
    output logic [EFUSE_OCT_BITS-1:0]       peek_data,
    output logic [15:0]                     pgm_cnt,
    output logic [ERR_W-1:0]                err,
    input  logic                            err_clr
);

    localparam int OCT_AW = EFUSE_DEPTH - EFUSE_BIT_IDX_W;

    efuse_state_e                state_reg;
    logic                        aen_q_reg;
    logic                        aen_blk_reg;   // AEN already high at reset: wait for low
    logic [EFUSE_DEPTH-1:0]      a_lat_reg;
    logic [15:0]                 wcnt_reg;
    logic [EFUSE_OCT_BITS-1:0]   d_reg;
    logic [15:0]                 pgm_cnt_reg;

    logic                        rise;
    logic                        fall;
    logic [16:0]                 wcnt_p1;
    logic                        rd_short;
    logic                        rd_hit;
    logic                        d_load;
    logic                        pg_fire;
    logic                        pg_ok;
    logic [OCT_AW-1:0]           lat_oct;
    logic [EFUSE_BIT_IDX_W-1:0]  lat_bit;
    logic [EFUSE_OCT_BITS-1:0]   rd_data;

    assign rise    = AEN & ~aen_q_reg & ~aen_blk_reg;
    assign fall    = ~AEN & aen_q_reg;
    assign lat_oct = a_lat_reg[OCT_AW-1:0];
    assign lat_bit = a_lat_reg[EFUSE_DEPTH-1 -: EFUSE_BIT_IDX_W];

    // wcnt holds (high cycles - 1) at the fall, so the pulse width is wcnt+1
    assign wcnt_p1  = {1'b0, wcnt_reg} + 17'd1;
    assign rd_short = (wcnt_p1 < 17'(RD_MIN_CYC));
    assign rd_hit   = (state_reg == ST_RD_PULSE) && (wcnt_reg == 16'(RD_MIN_CYC - 1));
    assign pg_fire  = (state_reg == ST_PG_PULSE) && fall;

`ifdef JLSEMI_SMIC_EFUSE_EMU_CHK_EN
    logic                avdd_ok_reg;
    logic                pg_short;
    logic [ERR_W-1:0]    err_set;
    logic [ERR_W-1:0]    err_reg;

    assign pg_short = (wcnt_p1 < 17'(PGM_MIN_CYC));
    assign d_load   = rd_hit;
    assign pg_ok    = pg_fire & ~pg_short & avdd_ok_reg;

    always_comb begin
        err_set            = '0;
        err_set[ERR_RD_PG] = (state_reg == ST_IDLE) && rise && !(RDEN ^ PGMEN);
        err_set[ERR_A_CHG] = (state_reg != ST_IDLE) && AEN && (A != a_lat_reg);
        err_set[ERR_SHORT] = ((state_reg == ST_RD_PULSE) && fall && rd_short)
                           | (pg_fire && pg_short);
        err_set[ERR_AVDD]  = pg_fire && !avdd_ok_reg;
    end

    // A same-cycle set beats err_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= '0;
        end else if (err_clr) begin
            err_reg <= err_set;
        end else begin
            err_reg <= err_reg | err_set;
        end
    end

    // avdd_ok covers every AEN-high cycle of the program pulse, rise included
    always_ff @(posedge clk) begin
        if (rst) begin
            avdd_ok_reg <= 1'b0;
        end else if ((state_reg == ST_IDLE) && rise) begin
            avdd_ok_reg <= AVDD_EN;
        end else if ((state_reg != ST_IDLE) && AEN && !AVDD_EN) begin
            avdd_ok_reg <= 1'b0;
        end
    end

    assign err = err_reg;
`else
    logic unused_inputs;

    // Short reads still return data, latched at the fall
    assign d_load        = rd_hit | ((state_reg == ST_RD_PULSE) && fall && rd_short);
    assign pg_ok         = pg_fire;
    assign err           = '0;
    assign unused_inputs = ^{err_clr, AVDD_EN};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            aen_q_reg   <= 1'b0;
            aen_blk_reg <= AEN;
            a_lat_reg   <= '0;
            wcnt_reg    <= '0;
            d_reg       <= '0;
            pgm_cnt_reg <= '0;
        end else begin
            aen_q_reg <= AEN;
            if (!AEN) begin
                aen_blk_reg <= 1'b0;
            end
            if (d_load) begin
                d_reg <= rd_data;
            end
            if (pg_ok && (pgm_cnt_reg != 16'hFFFF)) begin
                pgm_cnt_reg <= pgm_cnt_reg + 16'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (rise) begin
                        a_lat_reg <= A;
                        wcnt_reg  <= '0;
                        if (RDEN && !PGMEN) begin
                            state_reg <= ST_RD_PULSE;
                        end else if (PGMEN && !RDEN) begin
                            state_reg <= ST_PG_PULSE;
                        end else begin
                            state_reg <= ST_BAD_PULSE;
                        end
                    end
                end
                default: begin
                    if (fall) begin
                        state_reg <= ST_IDLE;
                    end else if (AEN && (wcnt_reg != 16'hFFFF)) begin
                        wcnt_reg <= wcnt_reg + 16'd1;
                    end
                end
            endcase
        end
    end

    jlsemi_util_smic_efuse_emu_array #(
        .OCT_AW (OCT_AW)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (pg_ok),
        .wr_oct    (lat_oct),
        .wr_bit    (lat_bit),
        .rd_oct    (lat_oct),
        .rd_data   (rd_data),
        .peek_oct  (peek_addr),
        .peek_data (peek_data)
    );

    assign D       = d_reg;
    assign pgm_cnt = pgm_cnt_reg;

endmodule

// File: tb/tb_jlsemi_util_smic_efuse_emu.sv
// ---------------------------------------------------------------------------
// tb_jlsemi_util_smic_efuse_emu
// Directed table of eFuse pulses with hand-computed results for both
// builds (with and without JLSEMI_SMIC_EFUSE_EMU_CHK_EN), plus hand-written
// sequences for read-data timing and reset in the middle of a program pulse.
// ---------------------------------------------------------------------------
module tb_jlsemi_util_smic_efuse_emu;

    logic        clk = 1'b0;
    logic        rst;
    logic        PGMEN, RDEN, AEN, AVDD_EN;
    logic [9:0]  A;
    logic [7:0]  D;
    logic [6:0]  peek_addr;
    logic [7:0]  peek_data;
    logic [15:0] pgm_cnt;
    logic [3:0]  err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jlsemi_util_smic_efuse_emu #(
        .EFUSE_DEPTH (10),
        .RD_MIN_CYC  (4),
        .PGM_MIN_CYC (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PGMEN     (PGMEN),
        .RDEN      (RDEN),
        .AEN       (AEN),
        .A         (A),
        .AVDD_EN   (AVDD_EN),
        .D         (D),
        .peek_addr (peek_addr),
        .peek_data (peek_data),
        .pgm_cnt   (pgm_cnt),
        .err       (err),
        .err_clr   (err_clr)
    );

    typedef struct {
        logic        pg;
        logic        rd;
        logic [9:0]  addr;
        int          n;         // AEN-high cycles
        int          avdd_low;  // cycle index with AVDD_EN low, -1 none
        int          a_chg;     // cycle index where A switches to addr2, -1 none
        logic [9:0]  addr2;
        logic        clr;       // pulse err_clr before the transaction
        logic [7:0]  d_c;       // expectations with checks enabled
        logic [3:0]  err_c;
        logic [15:0] cnt_c;
        logic [7:0]  peek_c;
        logic [7:0]  d_n;       // expectations with checks disabled
        logic [15:0] cnt_n;
        logic [7:0]  peek_n;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic pg, input logic rd, input logic [9:0] addr, input int n,
                         input int avdd_low, input int a_chg, input logic [9:0] addr2);
        PGMEN   = pg;
        RDEN    = rd;
        A       = addr;
        for (int i = 0; i < n; i++) begin
            AEN     = 1'b1;
            AVDD_EN = (i == avdd_low) ? 1'b0 : pg;
            if (i == a_chg) A = addr2;
            tick();
        end
        AEN = 1'b0;
        tick();
        PGMEN   = 1'b0;
        RDEN    = 1'b0;
        AVDD_EN = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [7:0]  exp_d;
        logic [3:0]  exp_err;
        logic [15:0] exp_cnt;
        logic [7:0]  exp_peek;

        //        pg rd  addr         n  avl  ach addr2        clr d_c    err_c cnt_c peek_c d_n    cnt_n peek_n
        vecs[0]  = '{0, 1, {3'd0,7'd5},  4, -1, -1, 10'd0,       0, 8'h00, 4'h0, 16'd0, 8'h00, 8'h00, 16'd0, 8'h00};
        vecs[1]  = '{1, 0, {3'd3,7'd5}, 16, -1, -1, 10'd0,       0, 8'h00, 4'h0, 16'd1, 8'h08, 8'h00, 16'd1, 8'h08};
        vecs[2]  = '{0, 1, {3'd0,7'd5},  4, -1, -1, 10'd0,       0, 8'h08, 4'h0, 16'd1, 8'h08, 8'h08, 16'd1, 8'h08};
        vecs[3]  = '{1, 0, {3'd1,7'd5}, 15, -1, -1, 10'd0,       0, 8'h08, 4'h4, 16'd1, 8'h08, 8'h08, 16'd2, 8'h0A};
        vecs[4]  = '{0, 1, {3'd0,7'd5},  4, -1, -1, 10'd0,       1, 8'h08, 4'h0, 16'd1, 8'h08, 8'h0A, 16'd2, 8'h0A};
        vecs[5]  = '{1, 0, {3'd0,7'd5}, 16,  7, -1, 10'd0,       0, 8'h08, 4'h8, 16'd1, 8'h08, 8'h0A, 16'd3, 8'h0B};
        vecs[6]  = '{1, 1, {3'd0,7'd5},  4, -1, -1, 10'd0,       1, 8'h08, 4'h1, 16'd1, 8'h08, 8'h0A, 16'd3, 8'h0B};
        vecs[7]  = '{0, 1, {3'd0,7'd5},  4, -1,  2, {3'd0,7'd6}, 1, 8'h08, 4'h2, 16'd1, 8'h08, 8'h0B, 16'd3, 8'h0B};
        vecs[8]  = '{1, 0, {3'd7,7'd6}, 16, -1, -1, 10'd0,       1, 8'h08, 4'h0, 16'd2, 8'h80, 8'h0B, 16'd4, 8'h80};
        vecs[9]  = '{0, 1, {3'd0,7'd6},  2, -1, -1, 10'd0,       0, 8'h08, 4'h4, 16'd2, 8'h80, 8'h80, 16'd4, 8'h80};
        vecs[10] = '{1, 0, {3'd3,7'd5}, 16, -1, -1, 10'd0,       1, 8'h08, 4'h0, 16'd3, 8'h08, 8'h80, 16'd5, 8'h0B};
        vecs[11] = '{0, 1, {3'd0,7'd5},  4, -1, -1, 10'd0,       0, 8'h08, 4'h0, 16'd3, 8'h08, 8'h0B, 16'd5, 8'h0B};

        rst       = 1'b1;
        PGMEN     = 1'b0;
        RDEN      = 1'b0;
        AEN       = 1'b0;
        AVDD_EN   = 1'b0;
        A         = '0;
        peek_addr = 7'd5;
        err_clr   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset D", {8'h00, D}, 16'h0000);
        check("reset err", {12'h000, err}, 16'h0000);
        check("reset pgm_cnt", pgm_cnt, 16'h0000);
        check("reset peek", {8'h00, peek_data}, 16'h0000);

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].clr) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
            end
            peek_addr = vecs[v].addr[6:0];
            pulse(vecs[v].pg, vecs[v].rd, vecs[v].addr, vecs[v].n,
                  vecs[v].avdd_low, vecs[v].a_chg, vecs[v].addr2);
`ifdef JLSEMI_SMIC_EFUSE_EMU_CHK_EN
            exp_d    = vecs[v].d_c;
            exp_err  = vecs[v].err_c;
            exp_cnt  = vecs[v].cnt_c;
            exp_peek = vecs[v].peek_c;
`else
            exp_d    = vecs[v].d_n;
            exp_err  = 4'h0;
            exp_cnt  = vecs[v].cnt_n;
            exp_peek = vecs[v].peek_n;
`endif
            $display("vec %0d: pg=%0d rd=%0d A=%h n=%0d D=%h err=%h cnt=%0d peek=%h",
                     v, vecs[v].pg, vecs[v].rd, vecs[v].addr, vecs[v].n, D, err, pgm_cnt, peek_data);
            check($sformatf("vec%0d D", v), {8'h00, D}, {8'h00, exp_d});
            check($sformatf("vec%0d err", v), {12'h000, err}, {12'h000, exp_err});
            check($sformatf("vec%0d pgm_cnt", v), pgm_cnt, exp_cnt);
            check($sformatf("vec%0d peek", v), {8'h00, peek_data}, {8'h00, exp_peek});
        end

        // D timing: a long read of octet 6 loads D at the 5th edge after the rise
`ifdef JLSEMI_SMIC_EFUSE_EMU_CHK_EN
        exp_d = 8'h08;
`else
        exp_d = 8'h0B;
`endif
        RDEN = 1'b1;
        A    = {3'd0, 7'd6};
        for (int i = 0; i < 6; i++) begin
            AEN = 1'b1;
            tick();
            if (i == 3) check("timing D before load", {8'h00, D}, {8'h00, exp_d});
            if (i == 4) check("timing D at load", {8'h00, D}, 16'h0080);
        end
        AEN = 1'b0;
        tick();
        RDEN = 1'b0;
        tick();
        $display("timing read: D=%h err=%h", D, err);
        check("timing err", {12'h000, err}, 16'h0000);

        // Reset lands at cycle 10 of a 16-cycle program pulse of bit 2, octet 7
        PGMEN     = 1'b1;
        AVDD_EN   = 1'b1;
        A         = {3'd2, 7'd7};
        peek_addr = 7'd7;
        for (int i = 0; i < 16; i++) begin
            AEN = 1'b1;
            rst = (i == 10);
            tick();
        end
        rst = 1'b0;
        AEN = 1'b0;
        tick();
        PGMEN   = 1'b0;
        AVDD_EN = 1'b0;
        tick();
        tick();
        $display("reset mid-pulse: D=%h err=%h cnt=%0d peek7=%h", D, err, pgm_cnt, peek_data);
        check("rstpulse pgm_cnt", pgm_cnt, 16'h0000);
        check("rstpulse peek oct7", {8'h00, peek_data}, 16'h0000);
        check("rstpulse D", {8'h00, D}, 16'h0000);
        check("rstpulse err", {12'h000, err}, 16'h0000);

        // Array was wiped: octet 5 reads back virgin
        peek_addr = 7'd5;
        pulse(1'b0, 1'b1, {3'd0, 7'd5}, 4, -1, -1, 10'd0);
        $display("post-reset read oct5: D=%h peek=%h", D, peek_data);
        check("post-reset peek oct5", {8'h00, peek_data}, 16'h0000);
        check("post-reset D oct5", {8'h00, D}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
